// File: rtl/mux_4.sv
// mux_4: result-select stage of the 16-bit RISC datapath.
// Chooses the ALU or shifter result for write-back. The chosen word is
// available combinationally and also in an enable-qualified register,
// together with zero/negative status flags that describe that register.
module mux_4 #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         M4,
    input  logic [N-1:0] ALU_out,
    input  logic [N-1:0] Shift_out,
    output logic [N-1:0] MUX_4_out,
    output logic [N-1:0] MUX_4_q,
    output logic         zero_q,
    output logic         neg_q
);

    logic [N-1:0] word_d, word_q;
    logic         zero_d, zero_q_r;
    logic         neg_d,  neg_q_r;

    // Result select. An unknown select yields an unknown word rather than
    // quietly favouring one source.
    always_comb begin
        MUX_4_out = '0;
        unique case (M4)
            1'b0:    MUX_4_out = ALU_out;
            1'b1:    MUX_4_out = Shift_out;
            default: MUX_4_out = 'x;
        endcase
    end

    // Next state of the output register: capture on enable, otherwise hold.
    // Flags are derived from the same word being captured, so they can
    // never disagree with MUX_4_q.
    always_comb begin
        word_d = word_q;
        zero_d = zero_q_r;
        neg_d  = neg_q_r;
        if (en) begin
            word_d = MUX_4_out;
            zero_d = (MUX_4_out == '0);
            neg_d  = MUX_4_out[N-1];
        end
    end

    // Output register with synchronous reset; reset wins over enable and
    // leaves an all-zero word, hence zero flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            zero_q_r <= 1'b1;
            neg_q_r  <= 1'b0;
        end else begin
            word_q   <= word_d;
            zero_q_r <= zero_d;
            neg_q_r  <= neg_d;
        end
    end

    assign MUX_4_q = word_q;
    assign zero_q  = zero_q_r;
    assign neg_q   = neg_q_r;

endmodule

// File: tb/tb_mux_4.sv
// Self-checking bench for mux_4: directed vector table, hand sequences for
// the combinational path and the N=8 variant, and a randomized run against
// a behavioural model of the output register.
module tb_mux_4;

    logic        clk = 1'b0;
    logic        rst, en, M4;
    logic [15:0] ALU_out, Shift_out;
    logic [15:0] MUX_4_out, MUX_4_q;
    logic        zero_q, neg_q;

    logic        rst8, en8, m48;
    logic [7:0]  alu8, sh8, out8, q8;
    logic        z8, n8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_4 #(.N(16)) dut (
        .clk(clk), .rst(rst), .en(en), .M4(M4),
        .ALU_out(ALU_out), .Shift_out(Shift_out),
        .MUX_4_out(MUX_4_out), .MUX_4_q(MUX_4_q),
        .zero_q(zero_q), .neg_q(neg_q)
    );

    mux_4 #(.N(8)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .M4(m48),
        .ALU_out(alu8), .Shift_out(sh8),
        .MUX_4_out(out8), .MUX_4_q(q8),
        .zero_q(z8), .neg_q(n8)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        m4;
        logic [15:0] alu;
        logic [15:0] sh;
        logic [15:0] exp_out;
        logic [15:0] exp_q;
        logic        exp_z;
        logic        exp_n;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the registered stage.
    logic [15:0] m_q;
    logic        m_z, m_n;

    initial begin
        rst = 1'b0; en = 1'b0; M4 = 1'b0; ALU_out = '0; Shift_out = '0;
        rst8 = 1'b1; en8 = 1'b0; m48 = 1'b0; alu8 = '0; sh8 = '0;

        // Combinational select, no clock edge needed between the two checks.
        @(negedge clk);
        M4 = 1'b0; Shift_out = 16'd10; ALU_out = 16'd20;
        #1 chk("comb_alu", MUX_4_out, 16'd20);
        #4 M4 = 1'b1;
        #1 chk("comb_shift", MUX_4_out, 16'd10);

        //          rst  en  m4  alu        sh         out        q          z     n
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'd20,   16'd10,   16'd20,   16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'd20,   16'h8001, 16'h8001, 16'h8001, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h8001, 16'h1234, 16'h8001, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h8001, 16'h1234, 16'h8001, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h1234, 16'h8001, 16'h1234, 16'h8001, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; M4 = vecs[i].m4;
            ALU_out = vecs[i].alu; Shift_out = vecs[i].sh;
            #1 chk($sformatf("v%0d_out_pre", i), MUX_4_out, vecs[i].exp_out);
            tick();
            chk($sformatf("v%0d_q", i),    MUX_4_q, vecs[i].exp_q);
            chk($sformatf("v%0d_zero", i), zero_q,  vecs[i].exp_z);
            chk($sformatf("v%0d_neg", i),  neg_q,   vecs[i].exp_n);
        end

        // N = 8: reset, then alternate selects with capture enabled.
        rst8 = 1'b1; en8 = 1'b1; alu8 = 8'hA5; sh8 = 8'h5A; m48 = 1'b0;
        tick();
        chk("n8_rst_q", q8, 8'h00);
        chk("n8_rst_z", z8, 1'b1);
        rst8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m48 = i[0];
            #1 chk($sformatf("n8_out%0d", i), out8, i[0] ? 8'h5A : 8'hA5);
            tick();
            chk($sformatf("n8_q%0d", i),   q8, i[0] ? 8'h5A : 8'hA5);
            chk($sformatf("n8_neg%0d", i), n8, i[0] ? 1'b0 : 1'b1);
            chk($sformatf("n8_z%0d", i),   z8, 1'b0);
        end

        // Randomized run; the first cycle is a reset so the model starts known.
        m_q = '0; m_z = 1'b1; m_n = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] sel;
            rst = (i == 0) || ($urandom_range(15) == 0);
            en  = ($urandom_range(3) != 0);
            M4  = $urandom_range(1);
            case ($urandom_range(3))
                0:       ALU_out = 16'h0000;
                1:       ALU_out = 16'h8000;
                default: ALU_out = 16'($urandom);
            endcase
            Shift_out = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
            sel = M4 ? Shift_out : ALU_out;
            #1 chk("rnd_out", MUX_4_out, sel);
            if (rst) begin
                m_q = 16'd0; m_z = 1'b1; m_n = 1'b0;
            end else if (en) begin
                m_q = sel;
                m_z = (sel == 16'd0);
                m_n = (sel >= 16'd32768);
            end
            tick();
            chk("rnd_q",    MUX_4_q, m_q);
            chk("rnd_zero", zero_q,  m_z);
            chk("rnd_neg",  neg_q,   m_n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
